// File: rtl/uart_rx_ctrl.sv
// UART receiver control stage: between-frame config updates, show-ahead byte FIFO and error status.
// Optional error counters are compiled in when UART_RX_ERR_CNT_EN is defined.
module uart_rx_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PRESCALE_W   = 6,
    parameter int unsigned RST_PRESCALE = 8,
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cfg_wr,
    input  logic                  cfg_par_en,
    input  logic                  cfg_par_typ,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    output logic                  cfg_busy,
    input  logic                  rx_busy,
    output logic                  rx_en,
    output logic                  par_en,
    output logic                  par_typ,
    output logic [PRESCALE_W-1:0] prescale,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_data_valid,
    input  logic                  rx_par_err,
    input  logic                  rx_frm_err,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    input  logic                  clr_status,
    output logic [ERR_CNT_W-1:0]  par_err_cnt,
    output logic [ERR_CNT_W-1:0]  frm_err_cnt
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic                  pend_par_en;
    logic                  pend_par_typ;
    logic [PRESCALE_W-1:0] pend_prescale;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= RUN;
            pend_par_en   <= 1'b1;
            pend_par_typ  <= 1'b0;
            pend_prescale <= PRESCALE_W'(RST_PRESCALE);
            par_en        <= 1'b1;
            par_typ       <= 1'b0;
            prescale      <= PRESCALE_W'(RST_PRESCALE);
        end else begin
            state <= state_nx;
            if (cfg_wr && state != APPLY) begin
                pend_par_en   <= cfg_par_en;
                pend_par_typ  <= cfg_par_typ;
                pend_prescale <= cfg_prescale;
            end
            if (state == APPLY) begin
                par_en   <= pend_par_en;
                par_typ  <= pend_par_typ;
                prescale <= pend_prescale;
            end
        end
    end

    always_comb begin
        state_nx = state;
        rx_en    = 1'b1;
        cfg_busy = 1'b0;
        unique case (state)
            RUN: begin
                if (cfg_wr) state_nx = HOLD;
            end
            HOLD: begin
                cfg_busy = 1'b1;
                if (!rx_busy) state_nx = APPLY;
            end
            APPLY: begin
                rx_en    = 1'b0;
                cfg_busy = 1'b1;
                state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  full, pop, push, drop;

    assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign push      = rx_data_valid && (!full || pop);
    assign drop      = rx_data_valid && full && !pop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= rx_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
            if (clr_status)  overflow <= 1'b0;
            else if (drop)   overflow <= 1'b1;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST || clr_status) begin
            par_err_cnt <= '0;
            frm_err_cnt <= '0;
        end else begin
            if (rx_par_err && par_err_cnt != '1) par_err_cnt <= par_err_cnt + ERR_CNT_W'(1);
            if (rx_frm_err && frm_err_cnt != '1) frm_err_cnt <= frm_err_cnt + ERR_CNT_W'(1);
        end
    end
`else
    logic unused_err;
    assign unused_err  = rx_par_err ^ rx_frm_err;
    assign par_err_cnt = '0;
    assign frm_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: vector table for config/FIFO paths plus hand sequences for
// HOLD, error counters (UART_RX_ERR_CNT_EN aware) and reset mid-config.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       cfg_wr, cfg_par_en, cfg_par_typ;
    logic [5:0] cfg_prescale;
    logic       cfg_busy, rx_busy, rx_en, par_en, par_typ;
    logic [5:0] prescale;
    logic [7:0] rx_data;
    logic       rx_data_valid, rx_par_err, rx_frm_err;
    logic [7:0] out_data;
    logic       out_valid, out_ready, overflow, clr_status;
    logic [1:0] par_err_cnt, frm_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef UART_RX_ERR_CNT_EN
    localparam int EXP_PAR_SAT = 3;
    localparam int EXP_FRM_ONE = 1;
`else
    localparam int EXP_PAR_SAT = 0;
    localparam int EXP_FRM_ONE = 0;
`endif

    uart_rx_ctrl #(
        .DATA_WIDTH  (8),
        .FIFO_DEPTH  (4),
        .PRESCALE_W  (6),
        .RST_PRESCALE(8),
        .ERR_CNT_W   (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .cfg_wr       (cfg_wr),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .cfg_prescale (cfg_prescale),
        .cfg_busy     (cfg_busy),
        .rx_busy      (rx_busy),
        .rx_en        (rx_en),
        .par_en       (par_en),
        .par_typ      (par_typ),
        .prescale     (prescale),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_par_err   (rx_par_err),
        .rx_frm_err   (rx_frm_err),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .clr_status   (clr_status),
        .par_err_cnt  (par_err_cnt),
        .frm_err_cnt  (frm_err_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       wr;
        logic       pe;
        logic [5:0] ps;
        logic       busy;
        logic       dv;
        logic [7:0] d;
        logic       rdy;
        logic       clr;
        logic       e_rx_en;
        logic       e_cfg_busy;
        logic       e_pe;
        logic [5:0] e_ps;
        logic       e_v;
        logic [7:0] e_d;
        logic       e_ovf;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input int wr, pe, ps, busy, dv, d, rdy, clr,
                                input int erx, ebusy, epe, eps, ev, ed, eovf);
        vec_t v;
        v.wr = 1'(wr);   v.pe = 1'(pe);     v.ps = 6'(ps);   v.busy = 1'(busy);
        v.dv = 1'(dv);   v.d = 8'(d);       v.rdy = 1'(rdy); v.clr = 1'(clr);
        v.e_rx_en = 1'(erx); v.e_cfg_busy = 1'(ebusy); v.e_pe = 1'(epe);
        v.e_ps = 6'(eps); v.e_v = 1'(ev); v.e_d = 8'(ed); v.e_ovf = 1'(eovf);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_wr = 0; cfg_par_en = 0; cfg_par_typ = 0; cfg_prescale = '0;
        rx_busy = 0; rx_data = '0; rx_data_valid = 0; rx_par_err = 0; rx_frm_err = 0;
        out_ready = 0; clr_status = 0;
    endtask

    initial begin
        // Config change with rx_busy=0: HOLD, APPLY, then new values visible
        vecs[0]  = mk(1,0,16,0, 0,8'h00,0,0,  1,1,1, 8, 0,8'h00,0);
        vecs[1]  = mk(0,0, 0,0, 0,8'h00,0,0,  0,1,1, 8, 0,8'h00,0);
        vecs[2]  = mk(0,0, 0,0, 0,8'h00,0,0,  1,0,0,16, 0,8'h00,0);
        vecs[3]  = mk(0,0, 0,0, 0,8'h00,0,0,  1,0,0,16, 0,8'h00,0);
        // Fill past full with out_ready=0, then drain
        vecs[4]  = mk(0,0, 0,0, 1,8'h11,0,0,  1,0,0,16, 1,8'h11,0);
        vecs[5]  = mk(0,0, 0,0, 1,8'h22,0,0,  1,0,0,16, 1,8'h11,0);
        vecs[6]  = mk(0,0, 0,0, 1,8'h33,0,0,  1,0,0,16, 1,8'h11,0);
        vecs[7]  = mk(0,0, 0,0, 1,8'h44,0,0,  1,0,0,16, 1,8'h11,0);
        vecs[8]  = mk(0,0, 0,0, 1,8'h55,0,0,  1,0,0,16, 1,8'h11,1);
        vecs[9]  = mk(0,0, 0,0, 0,8'h00,1,0,  1,0,0,16, 1,8'h22,1);
        vecs[10] = mk(0,0, 0,0, 0,8'h00,1,0,  1,0,0,16, 1,8'h33,1);
        vecs[11] = mk(0,0, 0,0, 0,8'h00,1,0,  1,0,0,16, 1,8'h44,1);
        vecs[12] = mk(0,0, 0,0, 0,8'h00,1,0,  1,0,0,16, 0,8'h00,1);
        vecs[13] = mk(0,0, 0,0, 0,8'h00,1,0,  1,0,0,16, 0,8'h00,1);
        vecs[14] = mk(0,0, 0,0, 0,8'h00,0,1,  1,0,0,16, 0,8'h00,0);
        // Refill, then push 0x66 into a full FIFO while popping
        vecs[15] = mk(0,0, 0,0, 1,8'h01,0,0,  1,0,0,16, 1,8'h01,0);
        vecs[16] = mk(0,0, 0,0, 1,8'h02,0,0,  1,0,0,16, 1,8'h01,0);
        vecs[17] = mk(0,0, 0,0, 1,8'h03,0,0,  1,0,0,16, 1,8'h01,0);
        vecs[18] = mk(0,0, 0,0, 1,8'h04,0,0,  1,0,0,16, 1,8'h01,0);
        vecs[19] = mk(0,0, 0,0, 1,8'h66,1,0,  1,0,0,16, 1,8'h02,0);
        vecs[20] = mk(0,0, 0,0, 0,8'h00,1,0,  1,0,0,16, 1,8'h03,0);
        vecs[21] = mk(0,0, 0,0, 0,8'h00,1,0,  1,0,0,16, 1,8'h04,0);
        vecs[22] = mk(0,0, 0,0, 0,8'h00,1,0,  1,0,0,16, 1,8'h66,0);
        vecs[23] = mk(0,0, 0,0, 0,8'h00,1,0,  1,0,0,16, 0,8'h00,0);

        idle_inputs();
        RST = 1;
        repeat (2) cycle();
        RST = 0;
        check("rst_par_en",   par_en,      1);
        check("rst_par_typ",  par_typ,     0);
        check("rst_prescale", prescale,    8);
        check("rst_out_valid",out_valid,   0);
        check("rst_rx_en",    rx_en,       1);
        check("rst_cfg_busy", cfg_busy,    0);
        check("rst_overflow", overflow,    0);
        check("rst_par_cnt",  par_err_cnt, 0);
        check("rst_frm_cnt",  frm_err_cnt, 0);

        for (int i = 0; i < NV; i++) begin
            cfg_wr = vecs[i].wr; cfg_par_en = vecs[i].pe; cfg_par_typ = 0;
            cfg_prescale = vecs[i].ps; rx_busy = vecs[i].busy;
            rx_data_valid = vecs[i].dv; rx_data = vecs[i].d;
            out_ready = vecs[i].rdy; clr_status = vecs[i].clr;
            cycle();
            check($sformatf("v%0d_rx_en", i),     rx_en,     vecs[i].e_rx_en);
            check($sformatf("v%0d_cfg_busy", i),  cfg_busy,  vecs[i].e_cfg_busy);
            check($sformatf("v%0d_par_en", i),    par_en,    vecs[i].e_pe);
            check($sformatf("v%0d_prescale", i),  prescale,  vecs[i].e_ps);
            check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_v);
            check($sformatf("v%0d_overflow", i),  overflow,  vecs[i].e_ovf);
            if (vecs[i].e_v) check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_d);
        end
        idle_inputs();

        // Config held off by rx_busy for 10 cycles; second write wins; frame captured in HOLD
        rx_busy = 1; cfg_wr = 1; cfg_par_en = 1; cfg_prescale = 16;
        cycle();
        cfg_wr = 0;
        check("hold_enter_busy", cfg_busy, 1);
        check("hold_enter_rx_en", rx_en, 1);
        for (int i = 1; i < 10; i++) begin
            cfg_wr = (i == 3); cfg_prescale = 32; cfg_par_en = 1; cfg_par_typ = 1;
            rx_data_valid = (i == 5); rx_data = 8'hA5;
            cycle();
            check($sformatf("hold%0d_rx_en", i), rx_en, 1);
            check($sformatf("hold%0d_prescale", i), prescale, 16);
            check($sformatf("hold%0d_cfg_busy", i), cfg_busy, 1);
        end
        idle_inputs();
        cycle();
        check("apply_rx_en", rx_en, 0);
        check("apply_cfg_busy", cfg_busy, 1);
        cfg_wr = 1; cfg_prescale = 5; cfg_par_en = 0;
        cycle();
        idle_inputs();
        check("hold_prescale_applied", prescale, 32);
        check("hold_par_typ_applied", par_typ, 1);
        check("hold_par_en_applied", par_en, 1);
        check("hold_cfg_busy_done", cfg_busy, 0);
        check("hold_frame_valid", out_valid, 1);
        check("hold_frame_data", out_data, 8'hA5);
        cycle();
        check("apply_wr_ignored_busy", cfg_busy, 0);
        check("apply_wr_ignored_ps", prescale, 32);
        out_ready = 1;
        cycle();
        out_ready = 0;
        check("hold_frame_popped", out_valid, 0);

        // Error counters: saturation at 3, simultaneous pulses, clear wins
        for (int i = 0; i < 4; i++) begin
            rx_par_err = 1;
            cycle();
        end
        check("cnt_par_sat", par_err_cnt, EXP_PAR_SAT);
        check("cnt_frm_zero", frm_err_cnt, 0);
        rx_par_err = 1; rx_frm_err = 1;
        cycle();
        check("cnt_both_par", par_err_cnt, EXP_PAR_SAT);
        check("cnt_both_frm", frm_err_cnt, EXP_FRM_ONE);
        rx_par_err = 0; rx_frm_err = 1; clr_status = 1;
        cycle();
        idle_inputs();
        check("cnt_clr_par", par_err_cnt, 0);
        check("cnt_clr_frm", frm_err_cnt, 0);

        // Reset during HOLD with a buffered byte
        rx_busy = 1; cfg_wr = 1; cfg_prescale = 40; cfg_par_en = 0; cfg_par_typ = 1;
        rx_data_valid = 1; rx_data = 8'h77;
        cycle();
        idle_inputs();
        rx_busy = 1;
        check("pre_rst_busy", cfg_busy, 1);
        check("pre_rst_valid", out_valid, 1);
        RST = 1;
        cycle();
        RST = 0; rx_busy = 0;
        check("midrst_prescale", prescale, 8);
        check("midrst_par_en", par_en, 1);
        check("midrst_par_typ", par_typ, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_cfg_busy", cfg_busy, 0);
        check("midrst_rx_en", rx_en, 1);
        repeat (3) cycle();
        check("midrst_pending_gone", prescale, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
